// File: rtl/trigger_seq.sv
// Multi-stage value/mask trigger sequencer on a sample stream; 1-cycle register slice, samples forwarded unchanged with event tags.
// Backpressure: sti_tready = sto_tready | ~sto_tvalid; FSM and counters only move on accepted samples.
module trigger_seq #(
  parameter int BAW = 8,
  parameter int BDW = 32,
  parameter int SDW = 32,
  parameter int SEW = 2,
  parameter int TMN = 4,
  parameter int TSN = 4,
  parameter int TCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  output logic           bus_wready,
  input  logic           bus_wvalid,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic [SEW-1:0] sto_tevent,
  output logic [SDW-1:0] sto_tdata,
  output logic           trg_done
);

  localparam int SIW = (TSN > 1) ? $clog2(TSN) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic           last;
    logic [SEW-1:0] evt;
    logic           mode;
    logic [TMN-1:0] sel;
  } stage_cfg_t;

  logic           live;
  state_t         state_q, state_d;
  logic [SIW-1:0] stage_q, stage_d;
  logic [TCW-1:0] cnt_q, cnt_d;

  logic [SDW-1:0] mval  [TMN];
  logic [SDW-1:0] mmask [TMN];
  stage_cfg_t     scfg  [TSN];
  logic [TCW-1:0] scnt  [TSN];

  logic           wr, ctl_wr, xfer;
  logic [TMN-1:0] hit;
  stage_cfg_t     cur;
  logic [TCW-1:0] thr;
  logic [TCW:0]   cnt_p1;
  logic           cond, reach, last_stage, stage_hit;
  logic [SEW-1:0] evt_tag;
  logic           unused_bits;

  assign unused_bits = ^bus_wdata;

  assign bus_wready = live;
  assign sti_tready = live & (sto_tready | ~sto_tvalid);
  assign wr         = bus_wvalid & bus_wready;
  assign ctl_wr     = wr & (bus_waddr == '0);
  assign xfer       = sti_tvalid & sti_tready;
  assign trg_done   = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) live <= 1'b0;
    else     live <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < TMN; m++) begin
        mval[m]  <= '0;
        mmask[m] <= '0;
      end
      for (int s = 0; s < TSN; s++) begin
        scfg[s] <= '0;
        scnt[s] <= '0;
      end
    end else if (wr) begin
      for (int m = 0; m < TMN; m++) begin
        if (bus_waddr == BAW'(16 + 2 * m)) mval[m]  <= bus_wdata[SDW-1:0];
        if (bus_waddr == BAW'(17 + 2 * m)) mmask[m] <= bus_wdata[SDW-1:0];
      end
      for (int s = 0; s < TSN; s++) begin
        if (bus_waddr == BAW'(32 + s))
          scfg[s] <= '{last: bus_wdata[24], evt: bus_wdata[16 +: SEW],
                       mode: bus_wdata[8], sel: bus_wdata[TMN-1:0]};
        if (bus_waddr == BAW'(48 + s)) scnt[s] <= bus_wdata[TCW-1:0];
      end
    end
  end

  // Matchers and stage qualification use the registered (pre-write) config.
  always_comb begin
    hit = '0;
    for (int m = 0; m < TMN; m++)
      hit[m] = (((sti_tdata ^ mval[m]) & mmask[m]) == '0);
  end

  assign cur        = scfg[stage_q];
  assign cond       = cur.mode ? (&(hit | ~cur.sel)) : (|(hit & cur.sel));
  assign thr        = (scnt[stage_q] == '0) ? TCW'(1) : scnt[stage_q];
  assign cnt_p1     = {1'b0, cnt_q} + (TCW + 1)'(1);
  assign reach      = (cnt_p1 >= {1'b0, thr});
  assign last_stage = cur.last | (stage_q == SIW'(TSN - 1));
  assign stage_hit  = (state_q == RUN) & xfer & cond & reach;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (ctl_wr) begin
      state_d = bus_wdata[0] ? RUN : IDLE;
      stage_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (xfer && cond) begin
            if (reach) begin
              cnt_d = '0;
              if (last_stage) state_d = DONE;
              else            stage_d = stage_q + SIW'(1);
            end else if (!(&cnt_q)) begin
              cnt_d = cnt_q + TCW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    evt_tag = '0;
    if (stage_hit) evt_tag = cur.evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sto_tvalid <= 1'b0;
      sto_tdata  <= '0;
      sto_tevent <= '0;
    end else if (sti_tready) begin
      sto_tvalid <= sti_tvalid;
      if (sti_tvalid) begin
        sto_tdata  <= sti_tdata;
        sto_tevent <= evt_tag;
      end
    end
  end

endmodule
